// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM states, key counts and priority helper for the key debouncer
// Contents:
//   NUM_KEYS, KEY_CODE_W  - channel count and width of the reported key index
//   key_fsm_e             - per-key debounce FSM states
//   lowest_index()        - index of the lowest set bit (0 when none set)
package key_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int KEY_CODE_W = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    HELD       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  // Scans from the top down so the lowest set index is the one left standing.
  function automatic logic [KEY_CODE_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] v);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce_x4_if.sv
// rtl/key_debounce_x4_if.sv - key input / key event bundle between board pins and control stage
// Signals:
//   key       [NUM_KEYS]   raw active-low keys (0 = pressed)
//   key_flag  [NUM_KEYS]   one-cycle pulse per accepted press / repeat
//   key_valid              one-cycle strobe, key_code is meaningful
//   key_code  [KEY_CODE_W] lowest index of the reported key
//   key_state [NUM_KEYS]   debounced level, 1 = held
// Modports: master drives keys and consumes events, slave is the debouncer.
interface key_debounce_x4_if;
  import key_pkg::*;

  logic [NUM_KEYS-1:0]   key;
  logic [NUM_KEYS-1:0]   key_flag;
  logic                  key_valid;
  logic [KEY_CODE_W-1:0] key_code;
  logic [NUM_KEYS-1:0]   key_state;

  modport master (output key, input key_flag, input key_valid, input key_code, input key_state);
  modport slave  (input key, output key_flag, output key_valid, output key_code, output key_state);

endinterface

// File: rtl/key_debounce_one.sv
// rtl/key_debounce_one.sv - single-key synchroniser, debounce FSM and optional auto-repeat
// Ports:
//   sys_clk   in   system clock
//   sys_rst   in   asynchronous active-high reset
//   key_raw   in   raw active-low key, asynchronous to sys_clk
//   key_flag  out  one-cycle pulse on accepted press (and repeat when enabled)
//   key_state out  debounced level, 1 = held
// Optional feature: KEY_AUTOREPEAT_EN adds the hold counter that re-pulses key_flag
// after LONG_CNT held cycles and then every REPEAT_CNT cycles.
module key_debounce_one
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [24:0] LONG_CNT   = 25'd24_999_999,
  parameter logic [22:0] REPEAT_CNT = 23'd4_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_flag,
  output logic key_state
);

  localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

  logic [1:0]  sync_q, sync_d;
  logic        key_s;
  key_fsm_e    state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        flag_q, flag_d;
  logic        level_q, level_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [24:0] LONG_LAST   = LONG_CNT - 25'd1;
  localparam logic [24:0] REPEAT_LAST = {2'b00, REPEAT_CNT} - 25'd1;

  logic [24:0] hold_q, hold_d;
  logic        rep_q, rep_d;
  logic [24:0] hold_last;

  // rep_q marks that the long-press pulse has fired; later pulses use the shorter period.
  assign hold_last = rep_q ? REPEAT_LAST : LONG_LAST;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{LONG_CNT, REPEAT_CNT};
`endif

  assign sync_d = {sync_q[0], key_raw};
  assign key_s  = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = 20'd1;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          flag_d  = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d   = 20'd1;
        end else begin
          cnt_d = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef KEY_AUTOREPEAT_EN
    // Counts only while the key stays in HELD; any excursion to REL_FILT restarts the long-press wait.
    hold_d = '0;
    rep_d  = 1'b0;
    if (state_q == HELD && !key_s) begin
      if (hold_q == hold_last) begin
        flag_d = 1'b1;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 25'd1;
        rep_d  = rep_q;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      level_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hold_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      level_q <= level_d;
`ifdef KEY_AUTOREPEAT_EN
      hold_q  <= hold_d;
      rep_q   <= rep_d;
`endif
    end
  end

  assign key_flag  = flag_q;
  assign key_state = level_q;

endmodule

// File: rtl/key_debounce_x4.sv
// rtl/key_debounce_x4.sv - four-channel key debouncer with registered priority event encoder
// Ports:
//   sys_clk  in   system clock, 50 MHz
//   sys_rst  in   asynchronous active-high reset
//   kif      key_debounce_x4_if.slave: key in; key_flag, key_valid, key_code, key_state out
// Optional feature: KEY_AUTOREPEAT_EN (auto-repeat pulses, implemented in key_debounce_one).
module key_debounce_x4
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [24:0] LONG_CNT   = 25'd24_999_999,
  parameter logic [22:0] REPEAT_CNT = 23'd4_999_999
) (
  input logic              sys_clk,
  input logic              sys_rst,
  key_debounce_x4_if.slave kif
);

  logic [NUM_KEYS-1:0]   flag_w;
  logic [NUM_KEYS-1:0]   state_w;
  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_one #(
      .CNT_MAX   (CNT_MAX),
      .LONG_CNT  (LONG_CNT),
      .REPEAT_CNT(REPEAT_CNT)
    ) u_key (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_raw  (kif.key[i]),
      .key_flag (flag_w[i]),
      .key_state(state_w[i])
    );
  end

  // Same-cycle higher-index events are dropped from key_code; they stay visible on key_flag.
  always_comb begin
    valid_d = |flag_w;
    code_d  = code_q;
    if (valid_d) code_d = lowest_index(flag_w);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign kif.key_flag  = flag_w;
  assign kif.key_state = state_w;
  assign kif.key_valid = valid_q;
  assign kif.key_code  = code_q;

endmodule

// File: tb/tb_key_debounce_x4.sv
// tb/tb_key_debounce_x4.sv - self-checking bench for key_debounce_x4 (optional KEY_AUTOREPEAT_EN)
module tb_key_debounce_x4;
  import key_pkg::*;

  localparam int CNT  = 24;
  localparam int LONG = 100;
  localparam int REP  = 40;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  key_debounce_x4_if kif();

  key_debounce_x4 #(
    .CNT_MAX   (20'd24),
    .LONG_CNT  (25'd100),
    .REPEAT_CNT(23'd40)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .kif    (kif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // Reference model: per key, an accepted level flips once CNT consecutive
  // synchronised samples disagree with it; a press emits a pulse.
  logic [3:0] h0, h1, lvl, prev_want, m_flag;
  logic       m_valid;
  logic [1:0] m_code;
  int         run [4];
  int         held[4];

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [3:0] exp_flags;
    int         exp_valids;
    logic [1:0] exp_code;
    logic [3:0] exp_state;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    h0 = 4'hF; h1 = 4'hF; lvl = '0; prev_want = '0;
    m_flag = '0; m_valid = 1'b0; m_code = '0;
    for (int i = 0; i < 4; i++) begin
      run[i] = 0;
      held[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] nf;
    logic       want;
    logic       found;
    if (sys_rst) begin
      model_reset();
      return;
    end
    nf = '0;
    for (int i = 0; i < 4; i++) begin
      want = ~h1[i];
      if (want != lvl[i]) begin
        held[i] = 0;
        run[i]++;
        if (run[i] == CNT) begin
          lvl[i] = want;
          run[i] = 0;
          if (want) nf[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
        if (lvl[i] && prev_want[i]) held[i]++;
        else held[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
        if (held[i] >= LONG && ((held[i] - LONG) % REP) == 0) nf[i] = 1'b1;
`endif
      end
      prev_want[i] = want;
    end
    m_valid = |m_flag;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_flag[i] && !found) begin
        m_code = 2'(i);
        found = 1'b1;
      end
    end
    m_flag = nf;
    h1 = h0;
    h0 = kif.key;
  endtask

  // One clock: model advances with the inputs the DUT is about to sample,
  // outputs are compared on the following falling edge.
  task automatic tick();
    model_edge();
    @(posedge sys_clk);
    edge_n++;
    @(negedge sys_clk);
    chk("model_flag_state_valid_code",
        {20'd0, kif.key_flag, kif.key_state, kif.key_valid, 1'b0, kif.key_code},
        {20'd0, m_flag, lvl, m_valid, 1'b0, m_code});
  endtask

  task automatic settle();
    kif.key = 4'hF;
    repeat (40) tick();
  endtask

  initial begin
    int e0, k, fall, nflag, nbounce, last_fall, flag_edge, ncode2, v, len, cyc, hits, valids;
    int pulses[$];
    int expp[$];
    int rem[4];

    vecs[0] = '{4'b1110, 40, 4'b0001, 1, 2'd0, 4'b0001};
    vecs[1] = '{4'b0101, 40, 4'b1010, 1, 2'd1, 4'b1010};
    vecs[2] = '{4'b1011, 40, 4'b0100, 1, 2'd2, 4'b0100};
    vecs[3] = '{4'b1110, 20, 4'b0000, 0, 2'd2, 4'b0000};
    vecs[4] = '{4'b0000, 40, 4'b1111, 1, 2'd0, 4'b1111};

    sys_rst = 1'b1;
    kif.key = 4'hF;
    model_reset();
    repeat (3) tick();
    chk("reset_flag",  {28'd0, kif.key_flag},  32'd0);
    chk("reset_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("reset_code",  {30'd0, kif.key_code},  32'd0);
    chk("reset_state", {28'd0, kif.key_state}, 32'd0);
    sys_rst = 1'b0;

    // Clean press of key 0, held 300 cycles: latency and repeat schedule.
    kif.key = 4'b1110;
    e0 = edge_n;
    for (int n = 0; n < 300; n++) begin
      tick();
      k = edge_n - 1 - e0;
      if (kif.key_flag[0]) pulses.push_back(k);
      if (k == 24) chk("state_before_accept", {31'd0, kif.key_state[0]}, 32'd0);
      if (k == 25) begin
        chk("flag_at_e25", {28'd0, kif.key_flag}, 32'h1);
        chk("state_at_e25", {31'd0, kif.key_state[0]}, 32'd1);
      end
      if (k == 26) chk("valid_code_at_e26", {29'd0, kif.key_valid, kif.key_code}, {29'd0, 1'b1, 2'd0});
    end
    expp.push_back(25);
`ifdef KEY_AUTOREPEAT_EN
    for (int t = 25 + LONG; t < 300; t += REP) expp.push_back(t);
`endif
    chk("pulse_count", pulses.size(), expp.size());
    foreach (expp[i]) begin
      if (i < pulses.size()) chk("pulse_edge", pulses[i], expp[i]);
    end

    // Release of key 0 with 10 cycles of bounce.
    e0 = edge_n;
    nflag = 0;
    for (int j = 0; j < 10; j++) begin
      kif.key[0] = (j % 2 == 0);
      tick();
      if (|kif.key_flag) nflag++;
      if (j == 9) chk("state_during_bounce", {31'd0, kif.key_state[0]}, 32'd1);
    end
    kif.key[0] = 1'b1;
    fall = -1;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (!kif.key_state[0] && fall < 0) fall = edge_n - 1 - e0;
      if (|kif.key_flag) nflag++;
    end
    chk("release_fall_edge", fall, 35);
    chk("release_no_flag", nflag, 0);

    // Table-driven patterns, each from a settled all-released state.
    for (int t = 0; t < 5; t++) begin
      logic [3:0] seen;
      settle();
      kif.key = vecs[t].key;
      seen = '0;
      valids = 0;
      hits = 0;
      for (int j = 0; j < vecs[t].hold; j++) begin
        tick();
        seen |= kif.key_flag;
        if (kif.key_valid) valids++;
        if (kif.key_flag != 4'b0 && kif.key_flag == vecs[t].exp_flags) hits++;
      end
      chk("vec_flags",  {28'd0, seen}, {28'd0, vecs[t].exp_flags});
      chk("vec_valids", valids, vecs[t].exp_valids);
      chk("vec_single_flag_cycle", hits, (vecs[t].exp_flags != 4'b0) ? 1 : 0);
      chk("vec_code",   {30'd0, kif.key_code}, {30'd0, vecs[t].exp_code});
      chk("vec_state",  {28'd0, kif.key_state}, {28'd0, vecs[t].exp_state});
    end

    // Random bounce on key 2, then a stable press.
    settle();
    v = 1;
    cyc = 0;
    nbounce = 0;
    last_fall = -1;
    while (cyc < 300) begin
      v = 1 - v;
      len = $urandom_range(1, 5);
      kif.key[2] = v[0];
      if (v == 0) last_fall = edge_n;
      for (int j = 0; j < len; j++) begin
        tick();
        if (|kif.key_flag) nbounce++;
        cyc++;
      end
    end
    if (kif.key[2]) begin
      kif.key[2] = 1'b0;
      last_fall = edge_n;
    end
    nflag = 0;
    flag_edge = -1;
    ncode2 = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (kif.key_flag[2]) begin
        nflag++;
        flag_edge = edge_n - 1;
      end
      if (kif.key_valid && kif.key_code == 2'd2) ncode2++;
    end
    chk("bounce_no_flag", nbounce, 0);
    chk("bounce_one_flag", nflag, 1);
    chk("bounce_flag_edge", flag_edge, last_fall + 25);
    chk("bounce_code2", ncode2, 1);

    // Reset in the middle of key 3's press filter, key 1 already held.
    settle();
    kif.key = 4'b1101;
    repeat (40) tick();
    kif.key = 4'b0101;
    repeat (17) tick();
    sys_rst = 1'b1;
    #1;
    chk("midreset_flag",  {28'd0, kif.key_flag},  32'd0);
    chk("midreset_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("midreset_code",  {30'd0, kif.key_code},  32'd0);
    chk("midreset_state", {28'd0, kif.key_state}, 32'd0);
    model_reset();
    @(negedge sys_clk);
    repeat (2) tick();
    sys_rst = 1'b0;
    e0 = edge_n;
    flag_edge = -1;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (kif.key_flag[3] && flag_edge < 0) flag_edge = edge_n - 1 - e0;
    end
    chk("post_reset_flag_edge", flag_edge, 25);

    // Free-running random stimulus on all keys against the model.
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          kif.key[i] = ~kif.key[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 90) : $urandom_range(1, 30);
        end
        rem[i]--;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
